micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_seq_pkg.sv | 67 ++++++
 rtl/micro_rotate.sv | 33 +++
 rtl/micro_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_micro_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_seq_pkg.sv
// Shared types and instruction-field constants for the operate-instruction micro-sequencer.
package micro_seq_pkg;

  localparam int unsigned WORD_W_DEF = 12;
  localparam int unsigned IR_W       = 9;

  typedef logic [WORD_W_DEF-1:0] word_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_G1_CLR,
    S_G1_CMP,
    S_G1_INC,
    S_G1_ROTA,
    S_G1_ROTB,
    S_G2_EVAL,
    S_G3_EXEC,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    GRP_NONE = 2'b00,
    GRP_G1   = 2'b01,
    GRP_G2   = 2'b10,
    GRP_G3   = 2'b11
  } group_e;

  typedef enum logic [1:0] {
    ROP_NONE,
    ROP_LEFT,
    ROP_RIGHT,
    ROP_BSW
  } rot_op_e;

  // Group decode bits
  localparam int unsigned IR_GRP = 8;
  localparam int unsigned IR_G3  = 0;
  localparam int unsigned IR_CLA = 7;

  // Group 1
  localparam int unsigned IR_CLL    = 6;
  localparam int unsigned IR_CMA    = 5;
  localparam int unsigned IR_CML    = 4;
  localparam int unsigned IR_ROT_HI = 3;
  localparam int unsigned IR_ROT_LO = 1;
  localparam int unsigned IR_IAC    = 0;

  // Group 2
  localparam int unsigned IR_SMA = 6;
  localparam int unsigned IR_SZA = 5;
  localparam int unsigned IR_SNL = 4;
  localparam int unsigned IR_AND = 3;
  localparam int unsigned IR_OSR = 2;
  localparam int unsigned IR_HLT = 1;

  // Group 3
  localparam int unsigned IR_MQA = 6;
  localparam int unsigned IR_MQL = 4;

  // {RAR,RAL,BSW} rotate codes
  localparam logic [2:0] ROT_BSW = 3'b001;
  localparam logic [2:0] ROT_RAL = 3'b010;
  localparam logic [2:0] ROT_RTL = 3'b011;
  localparam logic [2:0] ROT_RAR = 3'b100;
  localparam logic [2:0] ROT_RTR = 3'b101;

endpackage

// File: rtl/micro_rotate.sv
// Single-step rotate of the {L,AC} ring, or AC half swap.
module micro_rotate
  import micro_seq_pkg::*;
#(
  parameter int unsigned WORD_W = 12
) (
  input  logic [WORD_W-1:0] ac_i,
  input  logic              link_i,
  input  rot_op_e           op_i,
  output logic [WORD_W-1:0] ac_o,
  output logic              link_o
);

  localparam int unsigned HALF_W = WORD_W / 2;

  always_comb begin
    ac_o   = ac_i;
    link_o = link_i;
    case (op_i)
      ROP_LEFT: begin
        link_o = ac_i[WORD_W-1];
        ac_o   = {ac_i[WORD_W-2:0], link_i};
      end
      ROP_RIGHT: begin
        link_o = ac_i[0];
        ac_o   = {link_i, ac_i[WORD_W-1:1]};
      end
      ROP_BSW: ac_o = {ac_i[HALF_W-1:0], ac_i[WORD_W-1:HALF_W]};
      default: ;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Multi-cycle executor for operate-class instructions (groups 1, 2 and 3) with
// valid/ready request and result handshakes and a persistent MQ register.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int unsigned WORD_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IR_W-1:0]   in_ir,
  input  logic [WORD_W-1:0] in_ac,
  input  logic              in_link,
  input  logic [WORD_W-1:0] in_sr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_ac,
  output logic              out_link,
  output logic              out_skip,
  output logic              out_halt,
  output logic [1:0]        out_group,
  output logic [WORD_W-1:0] mq
);

  state_e              state_q, state_d;
  logic [7:0]          ir_q, ir_d;
  logic [WORD_W-1:0]   ac_q, ac_d;
  logic [WORD_W-1:0]   sr_q, sr_d;
  logic [WORD_W-1:0]   mq_q, mq_d;
  logic                link_q, link_d;
  logic                skip_q, skip_d;
  logic                halt_q, halt_d;
  group_e              grp_q, grp_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;

  logic [WORD_W-1:0]   inc_sum;
  logic                inc_carry;
  logic [WORD_W-1:0]   ac_cla;
  logic [2:0]          rot_code;
  logic                or_skip;
  rot_op_e             rot_op;
  logic [WORD_W-1:0]   rot_ac;
  logic                rot_link;

  assign {inc_carry, inc_sum} = {1'b0, ac_q} + (WORD_W+1)'(1);
  assign ac_cla   = ir_q[IR_CLA] ? '0 : ac_q;
  assign rot_code = ir_q[IR_ROT_HI:IR_ROT_LO];
  // Skip test uses the AC/L as accepted, ahead of any clear
  assign or_skip  = (ir_q[IR_SMA] & ac_q[WORD_W-1])
                  | (ir_q[IR_SZA] & (ac_q == '0))
                  | (ir_q[IR_SNL] & link_q);

  // RTL/RTR take one step in each rotate state; the rest only in ROTA
  always_comb begin
    rot_op = ROP_NONE;
    if (state_q == S_G1_ROTA) begin
      case (rot_code)
        ROT_RAL, ROT_RTL: rot_op = ROP_LEFT;
        ROT_RAR, ROT_RTR: rot_op = ROP_RIGHT;
        ROT_BSW:          rot_op = ROP_BSW;
        default:          rot_op = ROP_NONE;
      endcase
    end else if (state_q == S_G1_ROTB) begin
      case (rot_code)
        ROT_RTL: rot_op = ROP_LEFT;
        ROT_RTR: rot_op = ROP_RIGHT;
        default: rot_op = ROP_NONE;
      endcase
    end
  end

  micro_rotate #(
    .WORD_W (WORD_W)
  ) u_rotate (
    .ac_i   (ac_q),
    .link_i (link_q),
    .op_i   (rot_op),
    .ac_o   (rot_ac),
    .link_o (rot_link)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ac_d    = ac_q;
    sr_d    = sr_q;
    mq_d    = mq_q;
    link_d  = link_q;
    skip_d  = skip_q;
    halt_d  = halt_q;
    grp_d   = grp_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ir_d   = in_ir[7:0];
          ac_d   = in_ac;
          link_d = in_link;
          sr_d   = in_sr;
          skip_d = 1'b0;
          halt_d = 1'b0;
          if (!in_ir[IR_GRP]) begin
            grp_d   = GRP_G1;
            state_d = S_G1_CLR;
          end else if (!in_ir[IR_G3]) begin
            grp_d   = GRP_G2;
            state_d = S_G2_EVAL;
          end else begin
            grp_d   = GRP_G3;
            state_d = S_G3_EXEC;
          end
        end
      end
      S_G1_CLR: begin
        if (ir_q[IR_CLA]) ac_d = '0;
        if (ir_q[IR_CLL]) link_d = 1'b0;
        state_d = S_G1_CMP;
      end
      S_G1_CMP: begin
        if (ir_q[IR_CMA]) ac_d = ~ac_q;
        if (ir_q[IR_CML]) link_d = ~link_q;
        state_d = S_G1_INC;
      end
      S_G1_INC: begin
        if (ir_q[IR_IAC]) begin
          ac_d   = inc_sum;
          link_d = link_q ^ inc_carry;
        end
        state_d = S_G1_ROTA;
      end
      S_G1_ROTA: begin
        ac_d    = rot_ac;
        link_d  = rot_link;
        state_d = S_G1_ROTB;
      end
      S_G1_ROTB: begin
        ac_d    = rot_ac;
        link_d  = rot_link;
        state_d = S_DONE;
      end
      S_G2_EVAL: begin
        skip_d  = ir_q[IR_AND] ? ~or_skip : or_skip;
        ac_d    = ac_cla | (ir_q[IR_OSR] ? sr_q : '0);
        halt_d  = ir_q[IR_HLT];
        state_d = S_DONE;
      end
      S_G3_EXEC: begin
        case ({ir_q[IR_MQA], ir_q[IR_MQL]})
          2'b10: ac_d = ac_cla | mq_q;
          2'b01: begin
            mq_d = ac_cla;
            ac_d = '0;
          end
          2'b11: begin
            mq_d = ac_cla;
            ac_d = mq_q;
          end
          default: ac_d = ac_cla;
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      ac_q    <= '0;
      sr_q    <= '0;
      mq_q    <= '0;
      link_q  <= 1'b0;
      skip_q  <= 1'b0;
      halt_q  <= 1'b0;
      grp_q   <= GRP_NONE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      sr_q    <= sr_d;
      mq_q    <= mq_d;
      link_q  <= link_d;
      skip_q  <= skip_d;
      halt_q  <= halt_d;
      grp_q   <= grp_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_ac    = ac_q;
  assign out_link  = link_q;
  assign out_skip  = skip_q;
  assign out_halt  = halt_q;
  assign out_group = grp_q;
  assign mq        = mq_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: directed operate instructions, stall and mid-flight reset.
module tb_micro_sequencer;

  localparam int unsigned W = 12;

  typedef struct packed {
    logic [W-1:0] ac;
    logic         link;
    logic         skip;
    logic         halt;
    logic [1:0]   grp;
    logic [W-1:0] mq;
    int unsigned  lat;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [8:0]   in_ir;
  logic [W-1:0] in_ac;
  logic         in_link;
  logic [W-1:0] in_sr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_ac;
  logic         out_link;
  logic         out_skip;
  logic         out_halt;
  logic [1:0]   out_group;
  logic [W-1:0] mq;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   armed  = 1'b0;
  int   since  = 0;

  micro_sequencer #(.WORD_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ir     (in_ir),
    .in_ac     (in_ac),
    .in_link   (in_link),
    .in_sr     (in_sr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ac    (out_ac),
    .out_link  (out_link),
    .out_skip  (out_skip),
    .out_halt  (out_halt),
    .out_group (out_group),
    .mq        (mq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency, result compare on handshake, stability while stalled
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed = 1'b0;
        continue;
      end
      if (armed) since++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'(0));
        end else begin
          if (armed) begin
            chk("latency", 32'(since), 32'(exp_q[0].lat));
            armed = 1'b0;
          end
          if (out_ready) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ac",    32'(out_ac),    32'(e.ac));
            chk("link",  32'(out_link),  32'(e.link));
            chk("skip",  32'(out_skip),  32'(e.skip));
            chk("halt",  32'(out_halt),  32'(e.halt));
            chk("group", 32'(out_group), 32'(e.grp));
            chk("mq",    32'(mq),        32'(e.mq));
          end else begin
            chk("stall_ac",       32'(out_ac),   32'(exp_q[0].ac));
            chk("stall_link",     32'(out_link), 32'(exp_q[0].link));
            chk("stall_mq",       32'(mq),       32'(exp_q[0].mq));
            chk("stall_in_ready", 32'(in_ready), 32'(0));
          end
        end
      end
      if (in_valid && in_ready) begin
        armed = 1'b1;
        since = 0;
      end
    end
  end

  task automatic expect_res(input logic [W-1:0] ac, input logic l, input logic sk, input logic h,
                            input logic [1:0] g, input logic [W-1:0] m, input int unsigned lat);
    exp_t e;
    e.ac = ac; e.link = l; e.skip = sk; e.halt = h; e.grp = g; e.mq = m; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [8:0] ir, input logic [W-1:0] ac, input logic l, input logic [W-1:0] sr);
    int n = 0;
    in_valid = 1'b1; in_ir = ir; in_ac = ac; in_link = l; in_sr = sr;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("result_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [8:0] ir, input logic [W-1:0] ac, input logic l, input logic [W-1:0] sr,
                     input logic [W-1:0] e_ac, input logic e_l, input logic e_sk, input logic e_h,
                     input logic [1:0] e_g, input logic [W-1:0] e_mq, input int unsigned lat);
    expect_res(e_ac, e_l, e_sk, e_h, e_g, e_mq, lat);
    send(ir, ac, l, sr);
    drain();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'(1));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_ac"},    32'(out_ac),    32'(0));
    chk({tag, "_out_link"},  32'(out_link),  32'(0));
    chk({tag, "_out_skip"},  32'(out_skip),  32'(0));
    chk({tag, "_out_halt"},  32'(out_halt),  32'(0));
    chk({tag, "_out_group"}, 32'(out_group), 32'(0));
    chk({tag, "_mq"},        32'(mq),        32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_ir = '0; in_ac = '0; in_link = 1'b0; in_sr = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_reset_outs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Group 1: ir, ac, L, sr -> ac, L, skip, halt, group, mq, latency
    run(9'o041, 12'o0005, 1'b0, 12'o0000, 12'o7773, 1'b0, 1'b0, 1'b0, 2'b01, 12'o0000, 6);
    run(9'o001, 12'o7777, 1'b0, 12'o0000, 12'o0000, 1'b1, 1'b0, 1'b0, 2'b01, 12'o0000, 6);
    run(9'o006, 12'o4001, 1'b1, 12'o0000, 12'o0007, 1'b0, 1'b0, 1'b0, 2'b01, 12'o0000, 6);
    run(9'o010, 12'o0001, 1'b0, 12'o0000, 12'o0000, 1'b1, 1'b0, 1'b0, 2'b01, 12'o0000, 6);
    run(9'o012, 12'o0006, 1'b0, 12'o0000, 12'o0001, 1'b1, 1'b0, 1'b0, 2'b01, 12'o0000, 6);
    run(9'o002, 12'o1234, 1'b1, 12'o0000, 12'o3412, 1'b1, 1'b0, 1'b0, 2'b01, 12'o0000, 6);
    run(9'o300, 12'o1234, 1'b1, 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0, 2'b01, 12'o0000, 6);
    run(9'o360, 12'o1234, 1'b1, 12'o0000, 12'o7777, 1'b1, 1'b0, 1'b0, 2'b01, 12'o0000, 6);
    run(9'o014, 12'o1234, 1'b1, 12'o0000, 12'o1234, 1'b1, 1'b0, 1'b0, 2'b01, 12'o0000, 6);

    // Group 2
    run(9'o550, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0, 2'b10, 12'o0000, 2);
    run(9'o550, 12'o0003, 1'b0, 12'o0000, 12'o0003, 1'b0, 1'b1, 1'b0, 2'b10, 12'o0000, 2);
    run(9'o402, 12'o2525, 1'b1, 12'o0000, 12'o2525, 1'b1, 1'b0, 1'b1, 2'b10, 12'o0000, 2);
    run(9'o420, 12'o0000, 1'b1, 12'o0000, 12'o0000, 1'b1, 1'b1, 1'b0, 2'b10, 12'o0000, 2);
    run(9'o410, 12'o0000, 1'b1, 12'o0000, 12'o0000, 1'b1, 1'b1, 1'b0, 2'b10, 12'o0000, 2);
    run(9'o604, 12'o7000, 1'b0, 12'o0123, 12'o0123, 1'b0, 1'b0, 1'b0, 2'b10, 12'o0000, 2);
    run(9'o700, 12'o4000, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b1, 1'b0, 2'b10, 12'o0000, 2);

    // Group 3
    run(9'o421, 12'o1234, 1'b1, 12'o0000, 12'o0000, 1'b1, 1'b0, 1'b0, 2'b11, 12'o1234, 2);
    run(9'o521, 12'o5670, 1'b0, 12'o0000, 12'o1234, 1'b0, 1'b0, 1'b0, 2'b11, 12'o5670, 2);
    run(9'o701, 12'o1111, 1'b0, 12'o0000, 12'o5670, 1'b0, 1'b0, 1'b0, 2'b11, 12'o5670, 2);

    // Consumer stall with in_valid pulses that must be ignored
    out_ready = 1'b0;
    expect_res(12'o7777, 1'b0, 1'b0, 1'b0, 2'b01, 12'o5670, 6);
    send(9'o040, 12'o0000, 1'b0, 12'o0000);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("stall_reach_done", 32'(out_valid), 32'(1));
    end
    in_ir = 9'o001;
    repeat (5) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset while the request sits in G1_INC
    send(9'o001, 12'o0017, 1'b1, 12'o0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_reset_no_valid", 32'(out_valid), 32'(0));
    end
    @(posedge clk); #1;

    // MQ cleared by reset, MQA ORs in zero
    run(9'o501, 12'o0070, 1'b1, 12'o0000, 12'o0070, 1'b1, 1'b0, 1'b0, 2'b11, 12'o0000, 2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
